// File: rtl/symm_matmul_if.sv
// Operand/result bus of the 4x4 symmetric-orthogonalization matrix multiplier.
// Elements are named row/column, 1-based, matching the matrix notation.
interface symm_matmul_if #(parameter int W = 26);
    logic start_mm, tr_mm, busy_mm, done_mm;
    logic signed [W-1:0] a_11, a_12, a_13, a_14, a_21, a_22, a_23, a_24;
    logic signed [W-1:0] a_31, a_32, a_33, a_34, a_41, a_42, a_43, a_44;
    logic signed [W-1:0] b_11, b_12, b_13, b_14, b_21, b_22, b_23, b_24;
    logic signed [W-1:0] b_31, b_32, b_33, b_34, b_41, b_42, b_43, b_44;
    logic signed [W-1:0] o_11, o_12, o_13, o_14, o_21, o_22, o_23, o_24;
    logic signed [W-1:0] o_31, o_32, o_33, o_34, o_41, o_42, o_43, o_44;

    modport master (
        output start_mm, tr_mm,
        output a_11, a_12, a_13, a_14, a_21, a_22, a_23, a_24,
        output a_31, a_32, a_33, a_34, a_41, a_42, a_43, a_44,
        output b_11, b_12, b_13, b_14, b_21, b_22, b_23, b_24,
        output b_31, b_32, b_33, b_34, b_41, b_42, b_43, b_44,
        input  busy_mm, done_mm,
        input  o_11, o_12, o_13, o_14, o_21, o_22, o_23, o_24,
        input  o_31, o_32, o_33, o_34, o_41, o_42, o_43, o_44
    );

    modport slave (
        input  start_mm, tr_mm,
        input  a_11, a_12, a_13, a_14, a_21, a_22, a_23, a_24,
        input  a_31, a_32, a_33, a_34, a_41, a_42, a_43, a_44,
        input  b_11, b_12, b_13, b_14, b_21, b_22, b_23, b_24,
        input  b_31, b_32, b_33, b_34, b_41, b_42, b_43, b_44,
        output busy_mm, done_mm,
        output o_11, o_12, o_13, o_14, o_21, o_22, o_23, o_24,
        output o_31, o_32, o_33, o_34, o_41, o_42, o_43, o_44
    );
endinterface

// File: rtl/symm_matmul.sv
// Sequential 4x4 Q5.20 matrix multiplier, C = A*B or A*B^T, one output row
// per 4 cycles using four column MACs; result rounded and saturated.
module symm_matmul #(
    parameter int FRAC = 20,
    parameter int W    = 26
) (
    input logic         clk_mm,
    input logic         rst_mm,
    symm_matmul_if.slave bus
);
    localparam int PW = 2 * W;
    localparam int AW = PW + 2;
    localparam logic signed [AW-1:0] HALF = AW'(1) <<< (FRAC - 1);
    localparam logic signed [AW-1:0] MAXV = (AW'(1) <<< (W - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = -(AW'(1) <<< (W - 1));

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;
    state_t r_state, w_next;

    logic signed [W-1:0]  w_a [4][4], w_b [4][4];
    logic signed [W-1:0]  r_a [4][4], r_b [4][4], r_row [4][4], r_o [4][4];
    logic signed [W-1:0]  w_bsel [4], w_rnd [4];
    logic signed [PW-1:0] w_prod [4];
    logic signed [AW-1:0] r_acc [4], w_sum [4];
    logic                 r_tr, r_done, w_last;
    logic [1:0]           r_r, r_k;

    assign w_a[0][0] = bus.a_11; assign w_a[0][1] = bus.a_12; assign w_a[0][2] = bus.a_13; assign w_a[0][3] = bus.a_14;
    assign w_a[1][0] = bus.a_21; assign w_a[1][1] = bus.a_22; assign w_a[1][2] = bus.a_23; assign w_a[1][3] = bus.a_24;
    assign w_a[2][0] = bus.a_31; assign w_a[2][1] = bus.a_32; assign w_a[2][2] = bus.a_33; assign w_a[2][3] = bus.a_34;
    assign w_a[3][0] = bus.a_41; assign w_a[3][1] = bus.a_42; assign w_a[3][2] = bus.a_43; assign w_a[3][3] = bus.a_44;
    assign w_b[0][0] = bus.b_11; assign w_b[0][1] = bus.b_12; assign w_b[0][2] = bus.b_13; assign w_b[0][3] = bus.b_14;
    assign w_b[1][0] = bus.b_21; assign w_b[1][1] = bus.b_22; assign w_b[1][2] = bus.b_23; assign w_b[1][3] = bus.b_24;
    assign w_b[2][0] = bus.b_31; assign w_b[2][1] = bus.b_32; assign w_b[2][2] = bus.b_33; assign w_b[2][3] = bus.b_34;
    assign w_b[3][0] = bus.b_41; assign w_b[3][1] = bus.b_42; assign w_b[3][2] = bus.b_43; assign w_b[3][3] = bus.b_44;

    assign bus.o_11 = r_o[0][0]; assign bus.o_12 = r_o[0][1]; assign bus.o_13 = r_o[0][2]; assign bus.o_14 = r_o[0][3];
    assign bus.o_21 = r_o[1][0]; assign bus.o_22 = r_o[1][1]; assign bus.o_23 = r_o[1][2]; assign bus.o_24 = r_o[1][3];
    assign bus.o_31 = r_o[2][0]; assign bus.o_32 = r_o[2][1]; assign bus.o_33 = r_o[2][2]; assign bus.o_34 = r_o[2][3];
    assign bus.o_41 = r_o[3][0]; assign bus.o_42 = r_o[3][1]; assign bus.o_43 = r_o[3][2]; assign bus.o_44 = r_o[3][3];

    // done_mm is registered, so busy covers that cycle too
    assign bus.busy_mm = (r_state != S_IDLE) || r_done;
    assign bus.done_mm = r_done;

    // Round half toward +inf, then clamp into the Q5.20 range
    function automatic logic signed [W-1:0] round_sat(input logic signed [AW-1:0] x);
        logic signed [AW-1:0] t;
        t = x + HALF;
        t = t >>> FRAC;
        if (t > MAXV)      round_sat = MAXV[W-1:0];
        else if (t < MINV) round_sat = MINV[W-1:0];
        else               round_sat = t[W-1:0];
    endfunction

    always_comb begin
        w_last = (r_k == 2'd3);
        for (int j = 0; j < 4; j++) begin
            w_bsel[j] = r_tr ? r_b[j][r_k] : r_b[r_k][j];
            w_prod[j] = r_a[r_r][r_k] * w_bsel[j];
            w_sum[j]  = r_acc[j] + AW'(w_prod[j]);
            w_rnd[j]  = round_sat(w_sum[j]);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start_mm) w_next = S_CALC;
            S_CALC:  if (w_last && r_r == 2'd3) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_mm) begin
        if (rst_mm) begin
            r_state <= S_IDLE;
            r_tr    <= 1'b0;
            r_done  <= 1'b0;
            r_r     <= 2'd0;
            r_k     <= 2'd0;
            for (int i = 0; i < 4; i++) begin
                r_acc[i] <= '0;
                for (int j = 0; j < 4; j++) begin
                    r_a[i][j]   <= '0;
                    r_b[i][j]   <= '0;
                    r_row[i][j] <= '0;
                    r_o[i][j]   <= '0;
                end
            end
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: if (bus.start_mm) begin
                    r_tr <= bus.tr_mm;
                    r_a  <= w_a;
                    r_b  <= w_b;
                    r_r  <= 2'd0;
                    r_k  <= 2'd0;
                    for (int j = 0; j < 4; j++) r_acc[j] <= '0;
                end
                S_CALC: begin
                    r_k <= r_k + 2'd1;
                    if (w_last) r_r <= r_r + 2'd1;
                    for (int j = 0; j < 4; j++) begin
                        if (w_last) begin
                            r_row[r_r][j] <= w_rnd[j];
                            r_acc[j]      <= '0;
                        end else begin
                            r_acc[j] <= w_sum[j];
                        end
                    end
                end
                S_DONE:  r_o <= r_row;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_symm_matmul.sv
// Directed self-checking bench for symm_matmul: identity, transpose,
// saturation, rounding, busy handling, mid-operation reset and back-to-back.
module tb_symm_matmul;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    logic signed [25:0] ta [4][4], tbm [4][4], to [4][4];

    always #5 clk = ~clk;

    symm_matmul_if #(.W(26)) mm();
    symm_matmul #(.FRAC(20), .W(26)) dut (.clk_mm(clk), .rst_mm(rst), .bus(mm));

    assign mm.a_11 = ta[0][0]; assign mm.a_12 = ta[0][1]; assign mm.a_13 = ta[0][2]; assign mm.a_14 = ta[0][3];
    assign mm.a_21 = ta[1][0]; assign mm.a_22 = ta[1][1]; assign mm.a_23 = ta[1][2]; assign mm.a_24 = ta[1][3];
    assign mm.a_31 = ta[2][0]; assign mm.a_32 = ta[2][1]; assign mm.a_33 = ta[2][2]; assign mm.a_34 = ta[2][3];
    assign mm.a_41 = ta[3][0]; assign mm.a_42 = ta[3][1]; assign mm.a_43 = ta[3][2]; assign mm.a_44 = ta[3][3];
    assign mm.b_11 = tbm[0][0]; assign mm.b_12 = tbm[0][1]; assign mm.b_13 = tbm[0][2]; assign mm.b_14 = tbm[0][3];
    assign mm.b_21 = tbm[1][0]; assign mm.b_22 = tbm[1][1]; assign mm.b_23 = tbm[1][2]; assign mm.b_24 = tbm[1][3];
    assign mm.b_31 = tbm[2][0]; assign mm.b_32 = tbm[2][1]; assign mm.b_33 = tbm[2][2]; assign mm.b_34 = tbm[2][3];
    assign mm.b_41 = tbm[3][0]; assign mm.b_42 = tbm[3][1]; assign mm.b_43 = tbm[3][2]; assign mm.b_44 = tbm[3][3];
    assign to[0][0] = mm.o_11; assign to[0][1] = mm.o_12; assign to[0][2] = mm.o_13; assign to[0][3] = mm.o_14;
    assign to[1][0] = mm.o_21; assign to[1][1] = mm.o_22; assign to[1][2] = mm.o_23; assign to[1][3] = mm.o_24;
    assign to[2][0] = mm.o_31; assign to[2][1] = mm.o_32; assign to[2][2] = mm.o_33; assign to[2][3] = mm.o_34;
    assign to[3][0] = mm.o_41; assign to[3][1] = mm.o_42; assign to[3][2] = mm.o_43; assign to[3][3] = mm.o_44;

    // Pulse start for one edge; returns just after the accept edge
    task automatic start_op();
        @(negedge clk);
        mm.start_mm = 1'b1;
        @(posedge clk);
        #1 mm.start_mm = 1'b0;
    endtask

    // Edges until done_mm is seen, or -1 after a 40-cycle bound
    task automatic wait_done(output int n);
        n = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (mm.done_mm === 1'b1) begin
                n = c;
                return;
            end
        end
    endtask

    task automatic set_identity_b();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ta[i][j]  = (i == j) ? 26'sd1048576 : 26'sd0;
                tbm[i][j] = 26'((i * 4 + j - 8) * 500000 + 12345);
            end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mm.busy_mm !== 1'b0 || mm.done_mm !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags busy=%b done=%b required 0 0", mm.busy_mm, mm.done_mm);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (to[i][j] !== 26'sd0) begin
                    errors++;
                    $display("FAIL reset_o[%0d][%0d] got %0d required 0", i, j, to[i][j]);
                end
            end
        rst = 1'b0;
    endtask

    task automatic test_identity();
        int n;
        set_identity_b();
        mm.tr_mm = 1'b0;
        start_op();
        wait_done(n);
        checks++;
        if (n !== 17) begin
            errors++;
            $display("FAIL identity_latency got %0d required 17", n);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (to[i][j] !== 26'((i * 4 + j - 8) * 500000 + 12345)) begin
                    errors++;
                    $display("FAIL identity_o[%0d][%0d] got %0d required %0d", i, j, to[i][j], (i * 4 + j - 8) * 500000 + 12345);
                end
            end
        @(posedge clk);
        #1;
        checks++;
        if (mm.done_mm !== 1'b0) begin
            errors++;
            $display("FAIL identity_done_width done=%b required 0", mm.done_mm);
        end
    endtask

    // Rows filled with (i+1).0; transpose gives 4ij, plain product gives 10i, both clamped at 32.0
    task automatic test_transpose();
        int n;
        longint e;
        for (int t = 1; t >= 0; t--) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ta[i][j]  = 26'((i + 1) * 1048576);
                    tbm[i][j] = 26'((i + 1) * 1048576);
                end
            mm.tr_mm = t[0];
            start_op();
            wait_done(n);
            checks++;
            if (n !== 17) begin
                errors++;
                $display("FAIL transpose_latency tr=%0d got %0d required 17", t, n);
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    e = (t == 1) ? longint'(4 * (i + 1) * (j + 1)) * 1048576 : longint'(10 * (i + 1)) * 1048576;
                    if (e > 33554431) e = 33554431;
                    checks++;
                    if (longint'(to[i][j]) !== e) begin
                        errors++;
                        $display("FAIL transpose_o tr=%0d [%0d][%0d] got %0d required %0d", t, i, j, to[i][j], e);
                    end
                end
        end
    endtask

    task automatic test_saturation();
        int n;
        mm.tr_mm = 1'b0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ta[i][j]  = (s == 0) ? 26'sd8388608 : -26'sd8388608;
                    tbm[i][j] = 26'sd8388608;
                end
            start_op();
            wait_done(n);
            checks++;
            if (n !== 17) begin
                errors++;
                $display("FAIL sat_latency s=%0d got %0d required 17", s, n);
            end
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    checks++;
                    if (to[i][j] !== ((s == 0) ? 26'sd33554431 : -26'sd33554432)) begin
                        errors++;
                        $display("FAIL sat_o s=%0d [%0d][%0d] got %0d required %0d", s, i, j, to[i][j],
                                 (s == 0) ? 33554431 : -33554432);
                    end
                end
        end
    endtask

    task automatic test_rounding();
        int n;
        logic signed [25:0] av [3];
        logic signed [25:0] ev [3];
        av[0] = 26'sd1;  ev[0] = 26'sd1;
        av[1] = -26'sd1; ev[1] = 26'sd0;
        av[2] = 26'sd3;  ev[2] = 26'sd2;
        mm.tr_mm = 1'b0;
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    ta[i][j]  = '0;
                    tbm[i][j] = '0;
                end
            ta[0][0]  = av[v];
            tbm[0][0] = 26'sd524288;
            start_op();
            wait_done(n);
            checks++;
            if (n !== 17 || to[0][0] !== ev[v] || to[0][1] !== 26'sd0 || to[1][0] !== 26'sd0) begin
                errors++;
                $display("FAIL round a11=%0d latency %0d o11=%0d o12=%0d o21=%0d required 17 %0d 0 0",
                         av[v], n, to[0][0], to[0][1], to[1][0], ev[v]);
            end
        end
    endtask

    task automatic test_busy();
        logic signed [25:0] prev [4][4];
        int ndone = 0, dcyc = -1, bad = 0;
        set_identity_b();
        mm.tr_mm = 1'b0;
        prev = to;
        start_op();
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                mm.start_mm = 1'b1;
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        ta[i][j]  = (i == j) ? 26'sd2097152 : 26'sd0;
                        tbm[i][j] = 26'sd777;
                    end
            end
            if (c == 6) mm.start_mm = 1'b0;
            @(posedge clk);
            #1;
            if (mm.done_mm === 1'b1) begin
                ndone++;
                dcyc = c;
            end
            if (dcyc < 0 && (mm.busy_mm !== 1'b1 || to !== prev)) bad++;
        end
        checks++;
        if (ndone !== 1 || dcyc !== 17) begin
            errors++;
            $display("FAIL busy_done count %0d at %0d required 1 at 17", ndone, dcyc);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL busy_hold %0d cycles with busy low or o changed, required 0", bad);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (to[i][j] !== 26'((i * 4 + j - 8) * 500000 + 12345)) begin
                    errors++;
                    $display("FAIL busy_o[%0d][%0d] got %0d required %0d", i, j, to[i][j], (i * 4 + j - 8) * 500000 + 12345);
                end
            end
    endtask

    task automatic test_reset_mid();
        int n, ndone = 0;
        set_identity_b();
        mm.tr_mm = 1'b0;
        start_op();
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (mm.busy_mm !== 1'b0 || mm.done_mm !== 1'b0 || to[0][0] !== 26'sd0 || to[3][3] !== 26'sd0) begin
            errors++;
            $display("FAIL midreset_state busy=%b done=%b o11=%0d o44=%0d required 0 0 0 0",
                     mm.busy_mm, mm.done_mm, to[0][0], to[3][3]);
        end
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (mm.done_mm === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d pulses required 0", ndone);
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) tbm[i][j] = -tbm[i][j];
        start_op();
        wait_done(n);
        checks++;
        if (n !== 17 || to[0][0] !== 26'sd3987655 || to[3][3] !== -26'sd3512345) begin
            errors++;
            $display("FAIL midreset_restart latency %0d o11=%0d o44=%0d required 17 3987655 -3512345",
                     n, to[0][0], to[3][3]);
        end
    endtask

    task automatic test_back_to_back();
        int n1, n2, ndone = 0;
        set_identity_b();
        mm.tr_mm = 1'b0;
        @(negedge clk);
        mm.start_mm = 1'b1;
        @(posedge clk);
        #1;
        wait_done(n1);
        wait_done(n2);
        mm.start_mm = 1'b0;
        checks++;
        if (n1 !== 17 || n2 !== 18) begin
            errors++;
            $display("FAIL b2b_spacing first %0d then %0d required 17 then 18", n1, n2);
        end
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            if (mm.done_mm === 1'b1) ndone++;
        end
        checks++;
        if (ndone !== 0 || mm.busy_mm !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain pulses %0d busy %b required 0 0", ndone, mm.busy_mm);
        end
    endtask

    initial begin
        rst = 1'b1;
        mm.start_mm = 1'b0;
        mm.tr_mm = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ta[i][j]  = '0;
                tbm[i][j] = '0;
            end
        test_reset();
        test_identity();
        test_transpose();
        test_saturation();
        test_rounding();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
